rv32i_instr_encoder: RTL

- Inverse of the RV32I opcode/funct control decode: turns field-level instruction requests into 32-bit RV32I machine words.
- Emits each word with an auto-incrementing byte address to the instruction-memory write path, so benches and boot logic can load programs without a hand assembler.
- Expands the LI pseudo-op into LUI+ADDI through a small FSM.
- All traffic is valid/ready: one request in, one or two words out.

---
 rtl/rv32i_enc_pkg.sv | 39 +++
 rtl/rv32i_word_pack.sv | 51 +++++
 rtl/rv32i_instr_encoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_enc_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
// Opcodes, funct7 variants, request classes and the LI expansion FSM states.
package rv32i_enc_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    OP_R      = 4'd0,
    OP_I      = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LUI    = 4'd5,
    OP_JAL    = 4'd6,
    OP_JALR   = 4'd7,
    OP_LI     = 4'd8
  } op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } state_e;

  // True when v is representable as a 12-bit two's complement immediate.
  function automatic logic fits_simm12(input logic [31:0] v);
    return v[31:11] == {21{v[11]}};
  endfunction

endpackage

// File: rtl/rv32i_word_pack.sv
// Combinational field packer: one request class plus fields in, one RV32I word out.
// Also flags requests that cannot be encoded (bad class, misaligned or out-of-range offset).
module rv32i_word_pack
  import rv32i_enc_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  logic [6:0]  f7;
  logic [11:0] imm_i;

  assign f7 = alt ? F7_ALT : F7_BASE;

  always_comb begin
    word  = '0;
    bad   = 1'b0;
    // Shift-immediates carry funct7 in the upper immediate bits.
    imm_i = imm[11:0];
    if (funct3 == 3'b001 || funct3 == 3'b101) begin
      imm_i = {f7, imm[4:0]};
    end

    case (op)
      OP_R:      word = {f7, rs2, rs1, funct3, rd, OPC_R};
      OP_I:      word = {imm_i, rs1, funct3, rd, OPC_IMM};
      OP_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      OP_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      OP_BRANCH: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        bad  = imm[0] | (imm[31:12] != {20{imm[12]}});
      end
      OP_LUI:    word = {imm[31:12], rd, OPC_LUI};
      OP_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        bad  = imm[0] | (imm[31:20] != {12{imm[20]}});
      end
      OP_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      // LI is expanded by the caller into I/LUI requests before it reaches here.
      default:   bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Valid/ready RV32I encoder: one field-level request in, one or two words out, each tagged
// with an auto-incrementing byte address. LI expands to LUI+ADDI via a two-state FSM.
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              err,
  output logic [15:0]       word_count
);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [15:0]       word_count_q, word_count_d;
  logic [31:0]       li2_word_q, li2_word_d;

  op_e         req_op, p_op;
  logic        li_req, li_fits, li_tail;
  logic [31:0] li_sum;
  logic [4:0]  p_rs1;
  logic [2:0]  p_funct3;
  logic        p_alt;
  logic [31:0] p_imm, p_word, t_imm, t_word;
  logic        p_bad, t_bad, req_bad;
  logic        slot_free, accept, out_hs;

  assign req_op  = op_e'(in_op);
  assign li_req  = (req_op == OP_LI);
  assign li_fits = fits_simm12(in_imm);
  // Round so the sign-extended ADDI low part lands back on the requested value.
  assign li_sum  = in_imm + 32'h0000_0800;
  assign li_tail = li_req && !li_fits && (in_imm[11:0] != 12'h000);

  always_comb begin
    p_op     = req_op;
    p_rs1    = in_rs1;
    p_funct3 = in_funct3;
    p_alt    = in_alt;
    p_imm    = in_imm;
    if (li_req) begin
      p_op     = li_fits ? OP_I : OP_LUI;
      p_rs1    = 5'd0;
      p_funct3 = 3'b000;
      p_alt    = 1'b0;
      p_imm    = li_fits ? in_imm : {li_sum[31:12], 12'h000};
    end
  end

  assign t_imm = {{20{in_imm[11]}}, in_imm[11:0]};

  rv32i_word_pack u_pack_main (
    .op     (p_op),
    .rd     (in_rd),
    .rs1    (p_rs1),
    .rs2    (in_rs2),
    .funct3 (p_funct3),
    .alt    (p_alt),
    .imm    (p_imm),
    .word   (p_word),
    .bad    (p_bad)
  );

  rv32i_word_pack u_pack_tail (
    .op     (OP_I),
    .rd     (in_rd),
    .rs1    (in_rd),
    .rs2    (5'd0),
    .funct3 (3'b000),
    .alt    (1'b0),
    .imm    (t_imm),
    .word   (t_word),
    .bad    (t_bad)
  );

  assign req_bad   = p_bad || (li_tail && t_bad);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    li2_word_d   = li2_word_q;
    err_d        = accept && req_bad;

    // addr_q is the address of the presented word, or of the next one when the slot is empty.
    if (out_hs) begin
      addr_d       = addr_q + ADDR_W'(4);
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 16'd1;
    end else if (addr_load && !out_valid_q) begin
      addr_d = addr_in;
    end

    if (accept && !req_bad) begin
      out_valid_d = 1'b1;
      out_word_d  = p_word;
      if (li_tail) begin
        state_d    = S_LI2;
        li2_word_d = t_word;
      end
    end

    if (state_q == S_LI2 && slot_free) begin
      out_valid_d = 1'b1;
      out_word_d  = li2_word_q;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      addr_q       <= BASE_ADDR;
      err_q        <= 1'b0;
      word_count_q <= '0;
      li2_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      li2_word_q   <= li2_word_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_addr   = addr_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule
